// File: rtl/debounce_edge_detect.sv
// Synchronizes one raw asynchronous input, debounces it with a run-length counter FSM and
// emits registered edge pulses. Define DEBOUNCE_FALL_EN to add the o_fall pulse output.
module debounce_edge_detect #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic i_reset_n,
    input  logic i_raw,
    output logic o_level,
`ifdef DEBOUNCE_FALL_EN
    output logic o_fall,
`endif
    output logic o_rise
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_e;

    localparam state_e RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
`ifdef DEBOUNCE_FALL_EN
    logic                   fall_q, fall_d;
`endif
    logic                   s;

    // Only sync_q[0] ever looks at i_raw; everything downstream sees the last stage.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], i_raw};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
`ifdef DEBOUNCE_FALL_EN
        fall_d  = 1'b0;
`endif
        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = STABLE_HI;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = WAIT_HI;
                        cnt_d   = CW'(1);
                    end
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = STABLE_LO;
                        level_d = 1'b0;
`ifdef DEBOUNCE_FALL_EN
                        fall_d  = 1'b1;
`endif
                    end else begin
                        state_d = WAIT_LO;
                        cnt_d   = CW'(1);
                    end
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
`ifdef DEBOUNCE_FALL_EN
                    fall_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = RESET_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
`ifdef DEBOUNCE_FALL_EN
            fall_q  <= 1'b0;
`endif
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
`ifdef DEBOUNCE_FALL_EN
            fall_q  <= fall_d;
`endif
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
`ifdef DEBOUNCE_FALL_EN
    assign o_fall  = fall_q;
`endif

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed bench for debounce_edge_detect: default instance plus a RESET_LEVEL=1 instance.
module tb_debounce_edge_detect;

    logic clk = 1'b0;
    logic i_reset_n;
    logic i_raw;
    logic raw_hi;
    logic o_level, o_rise;
    logic hi_level, hi_rise;
`ifdef DEBOUNCE_FALL_EN
    logic o_fall, hi_fall;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int rise_cnt = 0;
    int hi_rise_cnt = 0;

    debounce_edge_detect dut (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .i_raw     (i_raw),
        .o_level   (o_level),
`ifdef DEBOUNCE_FALL_EN
        .o_fall    (o_fall),
`endif
        .o_rise    (o_rise)
    );

    debounce_edge_detect #(.RESET_LEVEL(1'b1)) dut_hi (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .i_raw     (raw_hi),
        .o_level   (hi_level),
`ifdef DEBOUNCE_FALL_EN
        .o_fall    (hi_fall),
`endif
        .o_rise    (hi_rise)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_rise === 1'b1) rise_cnt++;
        if (hi_rise === 1'b1) hi_rise_cnt++;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        i_raw     = 1'b0;
        raw_hi    = 1'b1;
        tick(2);
        n_checks++;
        if (o_level !== 1'b0) begin n_fail++; $display("FAIL reset_level: got %b want 0", o_level); end
        n_checks++;
        if (o_rise !== 1'b0) begin n_fail++; $display("FAIL reset_rise: got %b want 0", o_rise); end
        n_checks++;
        if (hi_level !== 1'b1) begin n_fail++; $display("FAIL reset_hi_level: got %b want 1", hi_level); end
        i_reset_n = 1'b1;
        tick(10);
        n_checks++;
        if (o_level !== 1'b0) begin n_fail++; $display("FAIL release_level: got %b want 0", o_level); end
        n_checks++;
        if (rise_cnt !== 0) begin n_fail++; $display("FAIL release_rise_cnt: got %0d want 0", rise_cnt); end
        n_checks++;
        if (hi_level !== 1'b1) begin n_fail++; $display("FAIL release_hi_level: got %b want 1", hi_level); end
    endtask

    task automatic test_clean_rise();
        int base;
        base  = rise_cnt;
        i_raw = 1'b1;
        tick(1);  // E0
        tick(4);  // E0+4
        n_checks++;
        if (o_level !== 1'b0) begin n_fail++; $display("FAIL rise_early_level: got %b want 0", o_level); end
        tick(1);  // E0+5
        n_checks++;
        if (o_level !== 1'b1) begin n_fail++; $display("FAIL rise_level: got %b want 1", o_level); end
        n_checks++;
        if (o_rise !== 1'b1) begin n_fail++; $display("FAIL rise_pulse: got %b want 1", o_rise); end
        tick(1);
        n_checks++;
        if (o_rise !== 1'b0) begin n_fail++; $display("FAIL rise_pulse_end: got %b want 0", o_rise); end
        n_checks++;
        if (o_level !== 1'b1) begin n_fail++; $display("FAIL rise_level_hold: got %b want 1", o_level); end
        tick(5);
        n_checks++;
        if (rise_cnt - base !== 1) begin n_fail++; $display("FAIL rise_count: got %0d want 1", rise_cnt - base); end
    endtask

    task automatic test_fall();
        int base;
        base  = rise_cnt;
        i_raw = 1'b0;
        tick(1);  // E0
        tick(4);
        n_checks++;
        if (o_level !== 1'b1) begin n_fail++; $display("FAIL fall_early_level: got %b want 1", o_level); end
        tick(1);  // E0+5
        n_checks++;
        if (o_level !== 1'b0) begin n_fail++; $display("FAIL fall_level: got %b want 0", o_level); end
        n_checks++;
        if (o_rise !== 1'b0) begin n_fail++; $display("FAIL fall_rise: got %b want 0", o_rise); end
`ifdef DEBOUNCE_FALL_EN
        n_checks++;
        if (o_fall !== 1'b1) begin n_fail++; $display("FAIL fall_pulse: got %b want 1", o_fall); end
`endif
        tick(1);
`ifdef DEBOUNCE_FALL_EN
        n_checks++;
        if (o_fall !== 1'b0) begin n_fail++; $display("FAIL fall_pulse_end: got %b want 0", o_fall); end
`endif
        tick(5);
        n_checks++;
        if (rise_cnt !== base) begin n_fail++; $display("FAIL fall_rise_cnt: got %0d want %0d", rise_cnt, base); end
    endtask

    task automatic test_glitch();
        int base;
        base  = rise_cnt;
        i_raw = 1'b1;
        tick(3);
        i_raw = 1'b0;
        tick(10);
        n_checks++;
        if (o_level !== 1'b0) begin n_fail++; $display("FAIL glitch3_level: got %b want 0", o_level); end
        n_checks++;
        if (rise_cnt !== base) begin n_fail++; $display("FAIL glitch3_rise_cnt: got %0d want %0d", rise_cnt, base); end
        i_raw = 1'b1;
        tick(4);
        i_raw = 1'b0;
        tick(3);  // E0+6, just after acceptance at E0+5
        n_checks++;
        if (o_level !== 1'b1) begin n_fail++; $display("FAIL glitch4_level: got %b want 1", o_level); end
        tick(10);
        n_checks++;
        if (rise_cnt - base !== 1) begin n_fail++; $display("FAIL glitch4_rise_cnt: got %0d want 1", rise_cnt - base); end
        n_checks++;
        if (o_level !== 1'b0) begin n_fail++; $display("FAIL glitch4_settle: got %b want 0", o_level); end
    endtask

    task automatic test_bounce();
        logic [4:0] vals;
        int base;
        vals = 5'b01101;  // applied LSB first: 1,0,1,1,0
        base = rise_cnt;
        for (int i = 0; i < 5; i++) begin
            i_raw = vals[i];
            tick(1);
        end
        i_raw = 1'b1;
        tick(1);  // start of final stable run
        tick(4);
        n_checks++;
        if (o_level !== 1'b0) begin n_fail++; $display("FAIL bounce_early_level: got %b want 0", o_level); end
        tick(1);
        n_checks++;
        if (o_rise !== 1'b1) begin n_fail++; $display("FAIL bounce_pulse: got %b want 1", o_rise); end
        tick(5);
        n_checks++;
        if (rise_cnt - base !== 1) begin n_fail++; $display("FAIL bounce_rise_cnt: got %0d want 1", rise_cnt - base); end
        i_raw = 1'b0;
        tick(10);
    endtask

    task automatic test_toggle();
        int base;
        base = rise_cnt;
        for (int i = 0; i < 30; i++) begin
            i_raw = ~i_raw;
            tick(1);
        end
        i_raw = 1'b0;
        tick(10);
        n_checks++;
        if (o_level !== 1'b0) begin n_fail++; $display("FAIL toggle_level: got %b want 0", o_level); end
        n_checks++;
        if (rise_cnt !== base) begin n_fail++; $display("FAIL toggle_rise_cnt: got %0d want %0d", rise_cnt, base); end
    endtask

    task automatic test_reset_mid_wait();
        int base;
        base  = rise_cnt;
        i_raw = 1'b1;
        tick(1);  // E0
        tick(3);  // E0+3: WAIT_HI with cnt=2
        #3;
        i_reset_n = 1'b0;
        #1;
        n_checks++;
        if (o_level !== 1'b0) begin n_fail++; $display("FAIL midrst_level: got %b want 0", o_level); end
        n_checks++;
        if (o_rise !== 1'b0) begin n_fail++; $display("FAIL midrst_rise: got %b want 0", o_rise); end
        tick(4);
        n_checks++;
        if (rise_cnt !== base) begin n_fail++; $display("FAIL midrst_no_pulse: got %0d want %0d", rise_cnt, base); end
        i_reset_n = 1'b1;
        tick(5);  // release edge +5
        n_checks++;
        if (o_level !== 1'b0) begin n_fail++; $display("FAIL midrst_early_level: got %b want 0", o_level); end
        tick(1);
        n_checks++;
        if (o_rise !== 1'b1) begin n_fail++; $display("FAIL midrst_pulse: got %b want 1", o_rise); end
        n_checks++;
        if (o_level !== 1'b1) begin n_fail++; $display("FAIL midrst_level_after: got %b want 1", o_level); end
        tick(3);
        n_checks++;
        if (rise_cnt - base !== 1) begin n_fail++; $display("FAIL midrst_rise_cnt: got %0d want 1", rise_cnt - base); end
        i_raw = 1'b0;
        tick(10);
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_fall();
        test_glitch();
        test_bounce();
        test_toggle();
        test_reset_mid_wait();
        n_checks++;
        if (hi_level !== 1'b1) begin n_fail++; $display("FAIL hi_level_final: got %b want 1", hi_level); end
        n_checks++;
        if (hi_rise_cnt !== 0) begin n_fail++; $display("FAIL hi_rise_cnt: got %0d want 0", hi_rise_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
